// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_ctrl
//  Description : Shift-and-add unsigned multiplier controller. Time-shares an
//                external WIDTH-bit combinational adder, one multiplier bit per
//                cycle, producing a 2*WIDTH-bit product after WIDTH cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CNT_W-1:0]   cnt;
    logic               last_step;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and adder drive; adder inputs are zero unless calculating.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                busy  = 1'b1;
                add_a = hi;
                add_b = lo[0] ? m : '0;
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then shift the sum right into HI:LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m   <= a;
                        hi  <= '0;
                        lo  <= b;
                        cnt <= '0;
                    end
                end
                S_CALC: begin
                    // Carry-out becomes the new HI MSB, so no overflow is lost.
                    hi  <= {add_cout, add_sum[WIDTH-1:1]};
                    lo  <= {add_sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        product <= {add_cout, add_sum, lo[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_ctrl
//  Description : Self-checking bench for seq_mult_ctrl with an attached adder,
//                a timeline-based reference model and randomized operands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mult_ctrl;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [63:0]        product;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // The shared adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference timeline: an accept happens at edge e when start is high and
    // at least WIDTH+2 edges have passed since the previous accept.
    int          cyc      = 0;
    int          last_acc = -100000;
    logic [63:0] ma       = '0;
    logic [63:0] mb       = '0;
    logic [63:0] exp_prod = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                last_acc = -100000;
                exp_prod = '0;
            end else begin
                cyc = cyc + 1;
                if (cyc - last_acc == WIDTH) exp_prod = ma * mb;
                if (start && (cyc - last_acc >= WIDTH + 2)) begin
                    last_acc = cyc;
                    ma       = {32'b0, a};
                    mb       = {32'b0, b};
                end
            end
        end
    end

    // Partial-product high half before step s: (a * (b mod 2^s)) >> s.
    function automatic logic [31:0] exp_hi(input logic [63:0] m, input logic [63:0] bb, input int s);
        logic [63:0] mask;
        logic [63:0] t;
        mask = (64'h1 << s) - 64'h1;
        t    = (m * (bb & mask)) >> s;
        return t[31:0];
    endfunction

    // Compare DUT outputs against the timeline model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                int d;
                logic [63:0] sel;
                d = cyc - last_acc;
                chk("busy", {63'b0, busy}, {63'b0, (d >= 0 && d < WIDTH)});
                chk("done", {63'b0, done}, {63'b0, (d == WIDTH)});
                chk("product", product, exp_prod);
                chk("add_cin", {63'b0, add_cin}, 64'h0);
                if (d >= 0 && d < WIDTH) begin
                    sel = mb >> d;
                    chk("add_a_calc", {32'b0, add_a}, {32'b0, exp_hi(ma, mb, d)});
                    chk("add_b_calc", {32'b0, add_b}, sel[0] ? ma : 64'h0);
                end else begin
                    chk("add_a_idle", {32'b0, add_a}, 64'h0);
                    chk("add_b_idle", {32'b0, add_b}, 64'h0);
                end
            end
        end
    end

    // Advance to 2 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one operation, scramble inputs after acceptance, wait for done.
    task automatic do_op(input logic [31:0] aa, input logic [31:0] bb,
                         output logic [63:0] res, output int lat);
        bit got;
        got   = 0;
        res   = '0;
        lat   = -1;
        start = 1'b1;
        a     = aa;
        b     = bb;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            #2;
            if (done) begin
                got = 1;
                res = product;
                lat = i + 1;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done within 40 cycles");
        end
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        int          ndone;
        logic [31:0] ra;
        logic [31:0] rb;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk("reset_busy", {63'b0, busy}, 64'h0);
        chk("reset_done", {63'b0, done}, 64'h0);
        chk("reset_product", product, 64'h0);
        chk_en = 1;
        tick();

        // 3 x 1, product must persist.
        do_op(32'h3, 32'h1, res, lat);
        chk("p_3x1", res, 64'h3);
        chk("lat_3x1", 64'(lat), 64'd32);
        for (int i = 0; i < 10; i++) tick();
        #2;
        chk("p_3x1_hold", product, 64'h3);
        tick();

        // Max operands exercise the carry-out on every step.
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
        chk("p_max", res, 64'hFFFFFFFE_00000001);
        tick();
        do_op(32'h0, 32'h12345678, res, lat);
        chk("p_zero", res, 64'h0);
        tick();
        do_op(32'h80000000, 32'h2, res, lat);
        chk("p_msb", res, 64'h1_00000000);
        tick();

        // Start held high; operands disturbed mid-operation.
        ndone = 0;
        start = 1'b1;
        for (int i = 0; i < 102; i++) begin
            if ((i % 34) >= 10 && (i % 34) <= 20) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = 32'd5;
                b = 32'd7;
            end
            tick();
            if (i == 101) start = 1'b0;
            #2;
            if (done) begin
                ndone++;
                chk("p_held", product, 64'd35);
            end
            #0;
        end
        start = 1'b0;
        chk("held_done_count", 64'(ndone), 64'd3);
        for (int i = 0; i < 36; i++) tick();

        // Reset mid-operation at CALC cycle 10.
        start = 1'b1;
        a     = 32'hDEAD;
        b     = 32'hBEEF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {63'b0, busy}, 64'h0);
        chk("rst_done", {63'b0, done}, 64'h0);
        chk("rst_product", product, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            #2;
            if (done) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        tick();
        do_op(32'd6, 32'd7, res, lat);
        chk("p_6x7", res, 64'd42);
        chk("lat_6x7", 64'(lat), 64'd32);

        // Random regression.
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            tick();
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFFFFFF;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'h0;
                default: begin end
            endcase
            do_op(ra, rb, res, lat);
            chk("p_rand", res, {32'b0, ra} * {32'b0, rb});
            chk("lat_rand", 64'(lat), 64'd32);
        end
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
